// File: rtl/mem_burst_reader.sv
`default_nettype none
// ============================================================================
// Module     : mem_burst_reader
// Description: DEPTH x WIDTH memory with a write port; streams LEN-word bursts
//              from a start address over valid/ready, wrapping at DEPTH-1.
// Revision   : 1.0 - initial release
// ============================================================================
module mem_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 17,
    parameter int AW    = 5,
    parameter int LW    = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [LW-1:0]    len,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LW-1:0]    rd_count
);

    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_addr;
    logic [LW-1:0]      r_rem;
    logic               r_rej;
    logic               w_reject;
    logic               w_zero_len;

    assign w_reject   = (start_addr > c_last_addr);
    assign w_zero_len = (len == '0);

    // Storage is deliberately left out of reset so contents survive a clear.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= c_last_addr)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_reject || w_zero_len) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_SEND;
            S_SEND: begin
                if (rd_ready) begin
                    w_state_nxt = (r_rem == LW'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_addr   <= '0;
            r_rem    <= '0;
            r_rej    <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rej    <= w_reject;
                        r_addr   <= start_addr;
                        r_rem    <= len;
                        rd_count <= '0;
                    end
                end
                // Non-blocking read returns the pre-write word on a same-cycle write.
                S_FETCH: begin
                    rd_data  <= r_mem[r_addr];
                    rd_valid <= 1'b1;
                end
                S_SEND: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_count <= rd_count + LW'(1);
                        r_rem    <= r_rem - LW'(1);
                        r_addr   <= (r_addr == c_last_addr) ? '0 : r_addr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign err  = (r_state == S_DONE) && r_rej;

endmodule
`default_nettype wire
